nbody_pair_scheduler: RTL

Streams every ordered body pair (i, j), i ≠ j, from the body BRAM into the pipelined force calculator at one pair per cycle. It accumulates the returned force components per body i and presents one accumulated force per body on a ready/valid result port. It replaces the one-pair-at-a-time sequencing of the N-body top level and sits between the body BRAM read port, the force calculator and the body-update stage.

---
 rtl/nbody_pkg.sv | 24 ++
 rtl/nbody_tag_pipe.sv | 48 ++++
 rtl/nbody_pair_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nbody_pkg.sv
// nbody_pkg: shared body record, force width
// and scheduler state encoding for the N-body force pass.
package nbody_pkg;

  localparam int FORCE_W = 32;

  typedef struct packed {
    logic [31:0] pos_x;
    logic [31:0] pos_y;
    logic [15:0] mass;
  } body_t;

  localparam int BODY_W = $bits(body_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LATCH_I,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/nbody_tag_pipe.sv
// nbody_tag_pipe: enable-gated shift register tracking
// {valid, last, idx} alongside the force calculator.
module nbody_tag_pipe #(
  parameter int LATENCY = 6,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [IDX_W-1:0] in_idx,
  output logic             tail_valid,
  output logic             tail_last,
  output logic [IDX_W-1:0] tail_idx,
  output logic             empty
);

  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] l_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  // shift one stage per enabled cycle; new tag enters stage 0
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        idx_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0]   <= in_valid;
      l_q[0]   <= in_valid & in_last;
      idx_q[0] <= in_idx;
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k]   <= v_q[k-1];
        l_q[k]   <= l_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign tail_valid = v_q[LATENCY-1];
  assign tail_last  = l_q[LATENCY-1];
  assign tail_idx   = idx_q[LATENCY-1];
  assign empty      = ~|v_q;

endmodule

// File: rtl/nbody_pair_scheduler.sv
// nbody_pair_scheduler: streams all ordered (i,j) pairs into
// the force pipeline and accumulates one force per body i.
module nbody_pair_scheduler
  import nbody_pkg::*;
#(
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int LATENCY    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BODY_W-1:0]     rd_data,
  output logic                  fc_enable,
  output logic                  fc_valid_in,
  output logic [BODY_W-1:0]     fc_body_i,
  output logic [BODY_W-1:0]     fc_body_j,
  input  logic [FORCE_W-1:0]    fc_force_x,
  input  logic [FORCE_W-1:0]    fc_force_y,
  input  logic                  fc_valid_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_WIDTH-1:0] res_idx,
  output logic [FORCE_W-1:0]    res_fx,
  output logic [FORCE_W-1:0]    res_fy,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] PENULT = ADDR_WIDTH'(N - 2);

  sched_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  body_t body_i_q;

  logic                  pending_q;
  logic                  pend_last_q;
  logic [ADDR_WIDTH-1:0] pend_idx_q;

  logic [FORCE_W-1:0] acc_x_q, acc_y_q;
  logic [FORCE_W-1:0] sum_x, sum_y;

  logic                  en;
  logic [ADDR_WIDTH-1:0] last_j;
  logic [ADDR_WIDTH-1:0] j_inc;
  logic [ADDR_WIDTH-1:0] next_j;
  logic                  issue;
  logic                  issue_last;
  logic                  drain_ok;

  logic                  tail_valid;
  logic                  tail_last;
  logic [ADDR_WIDTH-1:0] tail_idx;
  logic                  tag_empty;

  // a result waiting on the consumer stalls the whole pass
  assign en = !(res_valid && !res_ready);

  assign last_j     = (i_q == LAST_I) ? PENULT : LAST_I;
  assign j_inc      = addr_q + 1'b1;
  assign next_j     = (j_inc == i_q) ? addr_q + ADDR_WIDTH'(2) : j_inc;
  assign issue      = (state_q == S_LATCH_I) || (state_q == S_STREAM);
  assign issue_last = issue && (addr_q == last_j);
  assign drain_ok   = tag_empty && !pending_q && res_valid && res_ready;

  // state, body counter and read address register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      addr_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      i_q     <= i_d;
      addr_q  <= addr_d;
    end
  end

  // next state; addr_d is the address presented in the next state
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD_I;
          i_d     = '0;
          addr_d  = '0;
        end
      end
      S_LOAD_I: begin
        state_d = S_LATCH_I;
        addr_d  = (i_q == '0) ? ADDR_WIDTH'(1) : '0;
      end
      S_LATCH_I, S_STREAM: begin
        if (issue_last) begin
          if (i_q != LAST_I) begin
            state_d = S_LOAD_I;
            i_d     = i_q + 1'b1;
            addr_d  = i_q + 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_STREAM;
          addr_d  = next_j;
        end
      end
      S_DRAIN: begin
        if (drain_ok) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // status and pipeline-control outputs
  always_comb begin
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);
    fc_enable   = en && busy;
    fc_valid_in = pending_q && en;
  end

  assign rd_addr   = addr_q;
  assign fc_body_i = body_i_q;
  assign fc_body_j = rd_data;

  // latch body i and mark the pair whose j data arrives next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      body_i_q    <= '0;
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
      pend_idx_q  <= '0;
    end else if (en) begin
      if (state_q == S_LATCH_I) body_i_q <= body_t'(rd_data);
      pending_q   <= issue;
      pend_last_q <= issue_last;
      pend_idx_q  <= i_q;
    end
  end

  nbody_tag_pipe #(
    .LATENCY (LATENCY),
    .IDX_W   (ADDR_WIDTH)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (pending_q),
    .in_last    (pend_last_q),
    .in_idx     (pend_idx_q),
    .tail_valid (tail_valid),
    .tail_last  (tail_last),
    .tail_idx   (tail_idx),
    .empty      (tag_empty)
  );

  assign sum_x = acc_x_q + fc_force_x;
  assign sum_y = acc_y_q + fc_force_y;

  // accumulate per-body forces and hand finished sums to the consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_fx    <= '0;
      res_fy    <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (en && tail_valid) begin
        if (tail_last) begin
          res_fx    <= sum_x;
          res_fy    <= sum_y;
          res_idx   <= tail_idx;
          res_valid <= 1'b1;
          acc_x_q   <= '0;
          acc_y_q   <= '0;
        end else begin
          acc_x_q <= sum_x;
          acc_y_q <= sum_y;
        end
      end
    end
  end

  // sticky flag: force pipeline and tag pipe fell out of step
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (en && (fc_valid_out != tail_valid)) begin
      err <= 1'b1;
    end
  end

endmodule
